ahb_pixel_master: RTL and testbench
===================================

Name: ahb_pixel_master

Overview:
- AHB-Lite initiator that drives the sobel edge detector's AHB slave port from a simple block-request interface.
- Per request: one write transfer carrying a 4x4 tile of 4-bit pixels plus a 4-bit brightness value, then read transfers that poll until the slave reports a valid result pixel.
- Returns the 4-bit edge pixel, or a timeout flag, on a valid/ready result port.
- Sits between the host/test-harness logic and the detector top level.

Parameters:
- WRITE_ADDR, 32'h0000_0000, HADDR used for the pixel-block write.
- READ_ADDR, 32'h0000_0004, HADDR used for result polling reads.
- HSIZE_VAL, 3'b011, constant HSIZE driven on every transfer.
- POLL_LIMIT, 16, maximum result reads per block before timeout (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous active-low reset.
- blk_valid  input  1  request valid.
- blk_ready  output  1  request accepted when blk_valid & blk_ready at a rising edge.
- blk_pixels  input  64  tile; pixel[r][c] at bits 16r+4c+3 : 16r+4c.
- blk_brightness  input  4  brightness scalar for the tile.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed when res_valid & res_ready.
- res_pixel  output  4  edge magnitude pixel.
- res_timeout  output  1  qualifies res_valid: poll limit reached, res_pixel = 0.
- HSEL  output  1  slave select, high during any non-IDLE address phase.
- HADDR  output  32  transfer address.
- HTRANS  output  2  2'b00 IDLE, 2'b10 NONSEQ only.
- HWRITE  output  1  1 write / 0 read.
- HSIZE  output  3  always HSIZE_VAL.
- HWDATA  output  68  {brightness[3:0], pixels[63:0]}.
- HREADY  input  1  transfer-complete (slave HREADYOUT).
- HRDATA  input  68  bit 4 = result valid, bits 3:0 = pixel, others ignored.

Behaviour:
- All outputs registered. n_rst low at a rising edge gives:
  - state IDLE, HTRANS=00, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0
  - blk_ready=1, res_valid=0, res_pixel=0, res_timeout=0, poll count=0
- Reset mid-transfer abandons the transfer immediately; no HREADY wait.
- States:
  - IDLE: blk_ready=1. On accept, latch the tile and brightness, go to WR_ADDR. blk_ready=0 in every other state.
  - WR_ADDR: HTRANS=10, HSEL=1, HWRITE=1, HADDR=WRITE_ADDR. On HREADY=1, go to WR_DATA.
  - WR_DATA: HTRANS=00, HSEL=0. HWDATA = latched {brightness, pixels}, held stable while HREADY=0. On HREADY=1, go to RD_ADDR.
  - RD_ADDR: HTRANS=10, HSEL=1, HWRITE=0, HADDR=READ_ADDR. On HREADY=1, go to RD_DATA.
  - RD_DATA: HTRANS=00. HRDATA is sampled only at the edge where HREADY=1.
    - If HRDATA[4]=1: res_pixel=HRDATA[3:0], res_timeout=0, go to RESULT.
    - Else if poll count = POLL_LIMIT-1: res_pixel=0, res_timeout=1, go to RESULT.
    - Else: increment poll count, go back to RD_ADDR.
  - RESULT: res_valid=1, outputs held stable. On res_ready=1: res_valid=0, poll count=0, go to IDLE.
- Timing and latency:
  - The first NONSEQ appears the cycle after acceptance.
  - Zero-wait latency from accept to res_valid is 5 cycles when the first read returns valid.
  - Each extra poll adds 2 cycles; each HREADY-low cycle adds 1.
- No back-to-back pipelining: every data phase is followed by a new address phase or by IDLE.
- HWDATA is don't-care outside WR_DATA and holds its last value.
- blk_valid is ignored outside IDLE. A new block cannot be accepted in the same cycle that a result is consumed; acceptance happens in IDLE the next cycle.
- Poll count width is clog2(POLL_LIMIT)+1. With POLL_LIMIT=1, one read is issued, then either a result or a timeout.

Test Plan:
- Reset: n_rst low for 2 cycles during WR_DATA with HREADY=0 -> next edge HTRANS=00, HSEL=0, blk_ready=1, res_valid=0.
- Single block, zero wait:
  - Stimulus: pixels=64'h0000_0FF0_0FF0_0000, brightness=4'h3, slave returns HRDATA[4:0]=5'b1_1010 on the first read.
  - Response: HWDATA=68'h3_0000_0FF0_0FF0_0000 in the data phase, res_pixel=4'hA, res_timeout=0, res_valid 5 cycles after accept.
- Wait states: slave holds HREADY=0 for 3 cycles in the write data phase -> HWDATA stable all 3 cycles, read address phase starts the cycle after HREADY=1.
- Polling: slave returns valid=0 twice, then 5'b1_0111 -> three READ_ADDR address phases seen, res_pixel=4'h7.
- Timeout: POLL_LIMIT=4, slave never sets bit 4 -> exactly 4 reads, then res_valid=1, res_timeout=1, res_pixel=0.
- Result backpressure: res_ready=0 for 6 cycles -> res_valid and res_pixel held, blk_ready=0 while blk_valid=1; accept occurs the cycle after res_ready=1.

Source files
------------

// File: rtl/ahb_pixel_master.sv
// ahb_pixel_master: AHB-Lite initiator that writes a pixel tile to the sobel slave and polls for its edge result
module ahb_pixel_master #(
  parameter logic [31:0] WRITE_ADDR = 32'h0000_0000,
  parameter logic [31:0] READ_ADDR  = 32'h0000_0004,
  parameter logic [2:0]  HSIZE_VAL  = 3'b011,
  parameter int          POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [63:0] blk_pixels,
  input  logic [3:0]  blk_brightness,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_pixel,
  output logic        res_timeout,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [67:0] HWDATA,
  input  logic        HREADY,
  input  logic [67:0] HRDATA
);
  localparam int PW = $clog2(POLL_LIMIT) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RESULT} state_t;
  state_t state, state_n;
  logic [PW-1:0] poll_cnt, poll_cnt_n;
  logic [67:0] tile;
  logic [3:0] res_pixel_n;
  logic res_timeout_n;
  logic addr_n;
  logic unused_hrdata;
  assign unused_hrdata = ^HRDATA[67:5];
  assign HSIZE = HSIZE_VAL;
  assign addr_n = (state_n == WR_ADDR) || (state_n == RD_ADDR);
  // next-state, poll counting and result capture
  always_comb begin
    state_n = state;
    poll_cnt_n = poll_cnt;
    res_pixel_n = res_pixel;
    res_timeout_n = res_timeout;
    case (state)
      IDLE:    state_n = blk_valid ? WR_ADDR : IDLE;
      WR_ADDR: state_n = HREADY ? WR_DATA : WR_ADDR;
      WR_DATA: state_n = HREADY ? RD_ADDR : WR_DATA;
      RD_ADDR: state_n = HREADY ? RD_DATA : RD_ADDR;
      RD_DATA:
        if (HREADY) begin
          if (HRDATA[4]) begin
            res_pixel_n = HRDATA[3:0];
            res_timeout_n = 1'b0;
            state_n = RESULT;
          end else if (poll_cnt == POLL_LAST) begin
            res_pixel_n = 4'h0;
            res_timeout_n = 1'b1;
            state_n = RESULT;
          end else begin
            poll_cnt_n = poll_cnt + 1'b1;
            state_n = RD_ADDR;
          end
        end
      RESULT:
        if (res_ready) begin
          poll_cnt_n = '0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  // state, poll counter, tile latch and result/handshake registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      poll_cnt <= '0;
      tile <= '0;
      blk_ready <= 1'b1;
      res_valid <= 1'b0;
      res_pixel <= 4'h0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_n;
      poll_cnt <= poll_cnt_n;
      if (state == IDLE && blk_valid) tile <= {blk_brightness, blk_pixels};
      blk_ready <= state_n == IDLE;
      res_valid <= state_n == RESULT;
      res_pixel <= res_pixel_n;
      res_timeout <= res_timeout_n;
    end
  end
  // registered AHB address/control and write data, decoded from the next state
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      HTRANS <= 2'b00;
      HSEL <= 1'b0;
      HWRITE <= 1'b0;
      HADDR <= 32'h0;
      HWDATA <= 68'h0;
    end else begin
      HTRANS <= addr_n ? 2'b10 : 2'b00;
      HSEL <= addr_n;
      HWRITE <= (state_n == WR_ADDR) ? 1'b1 : (state_n == RD_ADDR) ? 1'b0 : HWRITE;
      HADDR <= (state_n == WR_ADDR) ? WRITE_ADDR : (state_n == RD_ADDR) ? READ_ADDR : HADDR;
      HWDATA <= (state_n == WR_DATA) ? tile : HWDATA;
    end
  end
endmodule

// File: tb/tb_ahb_pixel_master.sv
// tb_ahb_pixel_master: directed self-checking bench for the AHB pixel master
module tb_ahb_pixel_master;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic blk_valid = 1'b0;
  logic res_ready = 1'b0;
  logic HREADY = 1'b1;
  logic [63:0] blk_pixels = 64'h0;
  logic [3:0] blk_brightness = 4'h0;
  logic [67:0] HRDATA = 68'h0;
  logic blk_ready, res_valid, res_timeout, HSEL, HWRITE;
  logic [3:0] res_pixel;
  logic [31:0] HADDR;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [67:0] HWDATA;
  int checks = 0;
  int failures = 0;
  int reads, lat;

  always #5 clk = ~clk;

  ahb_pixel_master #(.POLL_LIMIT(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_pixels(blk_pixels), .blk_brightness(blk_brightness),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pixel(res_pixel), .res_timeout(res_timeout),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // counts read address phases until a result appears; returns valid data on read number valid_after
  task automatic poll_run(input int valid_after, output int rd, output int cy);
    rd = 0;
    cy = 1;
    for (int i = 0; i < 60 && !res_valid; i++) begin
      if (HTRANS == 2'b10 && !HWRITE && HADDR == 32'h4) begin
        rd++;
        if (rd == valid_after) HRDATA = 68'h17;
      end
      step();
      cy++;
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_htrans", 68'(HTRANS), 68'(2'b00));
    chk("rst_hsel", 68'(HSEL), 68'(1'b0));
    chk("rst_hwrite", 68'(HWRITE), 68'(1'b0));
    chk("rst_haddr", 68'(HADDR), 68'(32'h0));
    chk("rst_hwdata", HWDATA, 68'h0);
    chk("rst_blk_ready", 68'(blk_ready), 68'(1'b1));
    chk("rst_res_valid", 68'(res_valid), 68'(1'b0));
    chk("rst_res_pixel", 68'(res_pixel), 68'(4'h0));
    chk("rst_res_timeout", 68'(res_timeout), 68'(1'b0));
    chk("hsize", 68'(HSIZE), 68'(3'b011));
    n_rst = 1'b1;
    blk_pixels = 64'h0000_0FF0_0FF0_0000;
    blk_brightness = 4'h3;
    HRDATA = 68'h1A;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("t1_wa_htrans", 68'(HTRANS), 68'(2'b10));
    chk("t1_wa_hsel", 68'(HSEL), 68'(1'b1));
    chk("t1_wa_hwrite", 68'(HWRITE), 68'(1'b1));
    chk("t1_wa_haddr", 68'(HADDR), 68'(32'h0));
    chk("t1_wa_blk_ready", 68'(blk_ready), 68'(1'b0));
    step();
    chk("t1_wd_htrans", 68'(HTRANS), 68'(2'b00));
    chk("t1_wd_hsel", 68'(HSEL), 68'(1'b0));
    chk("t1_wd_hwdata", HWDATA, 68'h3_0000_0FF0_0FF0_0000);
    step();
    chk("t1_ra_htrans", 68'(HTRANS), 68'(2'b10));
    chk("t1_ra_hwrite", 68'(HWRITE), 68'(1'b0));
    chk("t1_ra_haddr", 68'(HADDR), 68'(32'h4));
    step();
    chk("t1_rd_htrans", 68'(HTRANS), 68'(2'b00));
    chk("t1_rd_res_valid", 68'(res_valid), 68'(1'b0));
    step();
    chk("t1_res_valid_c5", 68'(res_valid), 68'(1'b1));
    chk("t1_res_pixel", 68'(res_pixel), 68'(4'hA));
    chk("t1_res_timeout", 68'(res_timeout), 68'(1'b0));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t1_consumed", 68'(res_valid), 68'(1'b0));
    chk("t1_idle_ready", 68'(blk_ready), 68'(1'b1));
    blk_pixels = 64'h0123_4567_89AB_CDEF;
    blk_brightness = 4'h5;
    HRDATA = 68'h17;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    step();
    HREADY = 1'b0;
    chk("t2_wd_hwdata", HWDATA, 68'h5_0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_wait_htrans", 68'(HTRANS), 68'(2'b00));
      chk("t2_wait_hsel", 68'(HSEL), 68'(1'b0));
      chk("t2_wait_hwdata", HWDATA, 68'h5_0123_4567_89AB_CDEF);
    end
    HREADY = 1'b1;
    step();
    chk("t2_ra_htrans", 68'(HTRANS), 68'(2'b10));
    chk("t2_ra_haddr", 68'(HADDR), 68'(32'h4));
    chk("t2_ra_hwrite", 68'(HWRITE), 68'(1'b0));
    step();
    step();
    chk("t2_res_valid", 68'(res_valid), 68'(1'b1));
    chk("t2_res_pixel", 68'(res_pixel), 68'(4'h7));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    HRDATA = 68'h0F;
    blk_pixels = 64'hFFFF_0000_FFFF_0000;
    blk_brightness = 4'hF;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    poll_run(3, reads, lat);
    chk("t3_reads", 68'(reads), 68'(3));
    chk("t3_latency", 68'(lat), 68'(9));
    chk("t3_res_valid", 68'(res_valid), 68'(1'b1));
    chk("t3_res_pixel", 68'(res_pixel), 68'(4'h7));
    chk("t3_res_timeout", 68'(res_timeout), 68'(1'b0));
    blk_pixels = 64'h1111_2222_3333_4444;
    blk_brightness = 4'h9;
    HRDATA = 68'hF_FFFF_FFFF_FFFF_FFEF;
    blk_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_hold_valid", 68'(res_valid), 68'(1'b1));
      chk("t4_hold_pixel", 68'(res_pixel), 68'(4'h7));
      chk("t4_hold_blk_ready", 68'(blk_ready), 68'(1'b0));
      chk("t4_hold_htrans", 68'(HTRANS), 68'(2'b00));
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t4_consume_valid", 68'(res_valid), 68'(1'b0));
    chk("t4_consume_blk_ready", 68'(blk_ready), 68'(1'b1));
    chk("t4_no_same_cycle_accept", 68'(HTRANS), 68'(2'b00));
    step();
    blk_valid = 1'b0;
    chk("t4_accept_htrans", 68'(HTRANS), 68'(2'b10));
    chk("t4_accept_hwrite", 68'(HWRITE), 68'(1'b1));
    chk("t4_accept_blk_ready", 68'(blk_ready), 68'(1'b0));
    poll_run(0, reads, lat);
    chk("t5_reads", 68'(reads), 68'(4));
    chk("t5_latency", 68'(lat), 68'(11));
    chk("t5_res_valid", 68'(res_valid), 68'(1'b1));
    chk("t5_res_timeout", 68'(res_timeout), 68'(1'b1));
    chk("t5_res_pixel", 68'(res_pixel), 68'(4'h0));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t5_consumed", 68'(res_valid), 68'(1'b0));
    HRDATA = 68'h0;
    blk_pixels = 64'hDEAD_BEEF_CAFE_F00D;
    blk_brightness = 4'h1;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    step();
    HREADY = 1'b0;
    chk("t6_wd_hwdata", HWDATA, 68'h1_DEAD_BEEF_CAFE_F00D);
    n_rst = 1'b0;
    step();
    chk("t6_rst_htrans", 68'(HTRANS), 68'(2'b00));
    chk("t6_rst_hsel", 68'(HSEL), 68'(1'b0));
    chk("t6_rst_blk_ready", 68'(blk_ready), 68'(1'b1));
    chk("t6_rst_res_valid", 68'(res_valid), 68'(1'b0));
    chk("t6_rst_hwdata", HWDATA, 68'h0);
    step();
    n_rst = 1'b1;
    HREADY = 1'b1;
    step();
    chk("t6_post_htrans", 68'(HTRANS), 68'(2'b00));
    chk("t6_post_blk_ready", 68'(blk_ready), 68'(1'b1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
